// File: rtl/cve2_ex_sequencer.sv
// ID-side sequencer for the execution block: issues one instruction at a time, owns the
// intermediate-value registers and MAC accumulator, and retires results to the register file.
module cve2_ex_sequencer #(
   parameter int unsigned MaxCycles = 40  // legal range 2..255
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        instr_valid_i,
   output logic        instr_ready_o,
   input  logic        instr_mult_i,
   input  logic        instr_div_i,
   input  logic        instr_mac_i,
   input  logic [4:0]  instr_rd_i,
   input  logic        instr_kill_i,
   input  logic        acc_clr_i,
   output logic        alu_instr_first_cycle_o,
   output logic        mult_en_o,
   output logic        div_en_o,
   input  logic [1:0]  imd_val_we_i,
   input  logic [33:0] imd_val_d_i [2],
   output logic [33:0] imd_val_q_o [2],
   input  logic        ex_valid_i,
   input  logic [31:0] result_ex_i,
   output logic        rf_we_o,
   output logic [4:0]  rf_waddr_o,
   output logic [31:0] rf_wdata_o,
   output logic        busy_o,
   output logic        timeout_o
);

   typedef enum logic {
      IDLE = 1'b0,
      EXEC = 1'b1
   } state_e;

   localparam logic [7:0] CntLast = 8'(MaxCycles - 1);
   localparam logic [7:0] CntMax  = 8'hFF;

   state_e      r_state;
   logic        r_mult;
   logic        r_div;
   logic        r_mac;
   logic [4:0]  r_rd;
   logic [7:0]  r_cnt;
   logic [33:0] r_imd [2];
   logic [31:0] r_acc;
   logic        r_rf_we;
   logic [4:0]  r_rf_waddr;
   logic [31:0] r_rf_wdata;
   logic        r_timeout;

   logic w_exec;
   logic w_kill;
   logic w_done;
   logic w_abort;
   logic w_ready;
   logic w_accept;

   // Kill outranks completion, and completion outranks the watchdog.
   assign w_exec   = (r_state == EXEC);
   assign w_kill   = w_exec && instr_kill_i;
   assign w_done   = w_exec && ex_valid_i && !instr_kill_i;
   assign w_abort  = w_exec && !ex_valid_i && !instr_kill_i && (r_cnt == CntLast);
   // NOTE: ready is combinational so a completing instruction and the next issue share one cycle.
   assign w_ready  = !w_exec || w_done;
   assign w_accept = w_ready && instr_valid_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state    <= IDLE;
         r_mult     <= 1'b0;
         r_div      <= 1'b0;
         r_mac      <= 1'b0;
         r_rd       <= '0;
         r_cnt      <= '0;
         r_rf_we    <= 1'b0;
         r_rf_waddr <= '0;
         r_rf_wdata <= '0;
         r_timeout  <= 1'b0;
      end else begin
         // NOTE: non-blocking throughout, so every branch sees the pre-edge values of r_rd and r_cnt.
         r_rf_we   <= w_done && (r_rd != 5'd0);
         r_timeout <= w_abort;
         if (w_done) begin
            r_rf_waddr <= r_rd;
            r_rf_wdata <= result_ex_i;
         end
         if (w_accept) begin
            r_state <= EXEC;
            r_mult  <= instr_mult_i;
            r_div   <= instr_div_i;
            r_mac   <= instr_mac_i;
            r_rd    <= instr_rd_i;
            r_cnt   <= '0;
         end else if (w_done || w_kill || w_abort) begin
            r_state <= IDLE;
         end else if (w_exec && (r_cnt != CntMax)) begin
            r_cnt <= r_cnt + 8'd1;
         end
      end
   end

   // NOTE: the intermediate registers are architecturally visible after reset, so they are reset too.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_imd[0] <= '0;
         r_imd[1] <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (w_exec && !instr_kill_i && imd_val_we_i[i]) begin
               r_imd[i] <= imd_val_d_i[i];
            end
         end
      end
   end

   // A MAC result landing in the same cycle as a clear request takes precedence.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_acc <= '0;
      end else if (w_done && r_mac) begin
         r_acc <= result_ex_i;
      end else if (acc_clr_i) begin
         r_acc <= '0;
      end
   end

   assign instr_ready_o           = w_ready;
   assign busy_o                  = w_exec;
   assign alu_instr_first_cycle_o = w_exec && (r_cnt == 8'd0);
   assign mult_en_o               = w_exec && r_mult;
   assign div_en_o                = w_exec && r_div;
   assign imd_val_q_o[0]          = r_mac ? {2'b00, r_acc} : r_imd[0];
   assign imd_val_q_o[1]          = r_imd[1];
   assign rf_we_o                 = r_rf_we;
   assign rf_waddr_o              = r_rf_waddr;
   assign rf_wdata_o              = r_rf_wdata;
   assign timeout_o               = r_timeout;

endmodule
